// File: rtl/kamus_wb_port_arbiter.sv
// Regfile write-port arbiter: in-order WB stage vs. a FIFO-buffered long-latency unit.
// Optional macro KAMUS_WB_ARB_BYPASS_EN: an LLU result reaching an idle, empty port is written at once.
module kamus_wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     pipe_wr_en_i,
  input  logic [4:0]               pipe_rd_addr_i,
  input  logic [31:0]              pipe_wb_data_i,
  input  logic                     llu_valid_i,
  output logic                     llu_ready_o,
  input  logic [4:0]               llu_rd_addr_i,
  input  logic [31:0]              llu_data_i,
  output logic                     stall_o,
  output logic [31:0]              pend_mask_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o,
  output logic                     regfile_wr_en_o,
  output logic [4:0]               rd_addr_o,
  output logic [31:0]              wb_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic [4:0]    fifo_rd_mem   [DEPTH];
  logic [31:0]   fifo_data_mem [DEPTH];

  logic          empty, full, pipe_eff, llu_xfer, grant_fifo, bypass, push, pop;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   pend_mask;
  logic [PW-1:0] offs;

  always_comb begin
    empty      = (cnt_q == '0);
    full       = (cnt_q == CW'(DEPTH));
    pipe_eff   = pipe_wr_en_i && (pipe_rd_addr_i != 5'd0);
    llu_xfer   = llu_valid_i && !full;
    grant_fifo = !empty && (stall_q || !pipe_eff);
`ifdef KAMUS_WB_ARB_BYPASS_EN
    bypass     = empty && llu_xfer && (llu_rd_addr_i != 5'd0) && !pipe_eff && !stall_q;
`else
    bypass     = 1'b0;
`endif
    push       = llu_xfer && (llu_rd_addr_i != 5'd0) && !bypass;
    pop        = grant_fifo;

    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    if (grant_fifo) begin
      wr_en   = 1'b1;
      wr_addr = fifo_rd_mem[rd_ptr_q];
      wr_data = fifo_data_mem[rd_ptr_q];
    end else if (pipe_eff && !stall_q) begin
      wr_en   = 1'b1;
      wr_addr = pipe_rd_addr_i;
      wr_data = pipe_wb_data_i;
    end else if (bypass) begin
      wr_en   = 1'b1;
      wr_addr = llu_rd_addr_i;
      wr_data = llu_data_i;
    end

    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    if (empty || grant_fifo) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end

    // Force a drain cycle once the FIFO is full or its head has waited too long.
    stall_d = (cnt_d != '0) && ((cnt_d == CW'(DEPTH)) || (starve_d >= SW'(STARVE_LIM)));
  end

  // Entries between the read pointer and cnt_q slots later are the live ones.
  always_comb begin
    pend_mask = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ({1'b0, offs} < cnt_q) begin
        pend_mask[fifo_rd_mem[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  always_comb begin
    llu_ready_o     = rst_ni && !full;
    stall_o         = rst_ni && stall_q;
    fifo_cnt_o      = rst_ni ? cnt_q : '0;
    pend_mask_o     = rst_ni ? pend_mask : '0;
    regfile_wr_en_o = rst_ni && wr_en;
    rd_addr_o       = rst_ni ? wr_addr : 5'd0;
    wb_data_o       = rst_ni ? wr_data : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_q]   <= llu_rd_addr_i;
      fifo_data_mem[wr_ptr_q] <= llu_data_i;
    end
  end

endmodule
